// File: rtl/seq101_pkg.sv
// Shared definitions for the 101 serial sync protocol, used by both the
// transmitter and the sequence detector.
package seq101_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSyncA = 3'd1,
    StSyncB = 3'd2,
    StSyncC = 3'd3,
    StData  = 3'd4,
    StGap   = 3'd5
  } state_e;

  localparam logic [2:0]  SYNC_PATTERN = 3'b101;
  localparam int unsigned SYNC_LEN     = 3;
  localparam int unsigned GAP_CNT_W    = 4;

  // Counter width for a payload of w bits, never narrower than one bit.
  function automatic int unsigned bit_cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Sync bit transmitted in the idx-th sync cycle, first bit first.
  function automatic logic sync_bit(input logic [1:0] idx);
    logic [1:0] pos;
    pos = 2'(SYNC_LEN - 1) - idx;
    return SYNC_PATTERN[pos];
  endfunction

endpackage

// File: rtl/seq101_tx_if.sv
// Handshake and serial-line bundle between a word producer and seq101_tx.
interface seq101_tx_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              x;
  logic              frame_start;
  logic              frame_done;
  logic              busy;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  x,
    input  frame_start,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output x,
    output frame_start,
    output frame_done,
    output busy
  );

endinterface

// File: rtl/seq101_tx.sv
// Transmit side of the 101 protocol: accepts a word, then sends sync 1,0,1,
// the word MSB-first and GAP_CYCLES guard zeros; the line idles at 0.
module seq101_tx
  import seq101_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  seq101_tx_if.slave   bus
);

  localparam int unsigned BitCntW = bit_cnt_width(DATA_W);
  localparam logic [BitCntW-1:0]   BitLast = BitCntW'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] GapLast =
      (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;
  localparam bit HasGap = (GAP_CYCLES > 0);

  state_e               state_q;
  logic [DATA_W-1:0]    sreg_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [GAP_CNT_W-1:0] gap_cnt_q;
  logic                 x_q;
  logic                 ready_q;
  logic                 frame_start_q;
  logic                 frame_done_q;

  logic accept;
  logic data_penult;

  assign accept = ready_q & bus.valid;

  // Next DATA cycle is the last one; never true for a single-bit payload.
  assign data_penult = (DATA_W > 1) && (bit_cnt_q == BitCntW'(DATA_W - 2));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      x_q           <= 1'b0;
      ready_q       <= 1'b1;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          x_q <= 1'b0;
          if (accept) begin
            state_q       <= StSyncA;
            sreg_q        <= bus.data_in;
            x_q           <= sync_bit(2'd0);
            ready_q       <= 1'b0;
            frame_start_q <= 1'b1;
          end
        end
        StSyncA: begin
          state_q <= StSyncB;
          x_q     <= sync_bit(2'd1);
        end
        StSyncB: begin
          state_q <= StSyncC;
          x_q     <= sync_bit(2'd2);
        end
        StSyncC: begin
          state_q      <= StData;
          x_q          <= sreg_q[DATA_W-1];
          sreg_q       <= sreg_q << 1;
          bit_cnt_q    <= '0;
          frame_done_q <= (DATA_W == 1);
        end
        StData: begin
          if (bit_cnt_q == BitLast) begin
            x_q       <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            if (HasGap) begin
              state_q <= StGap;
            end else begin
              state_q <= StIdle;
              ready_q <= 1'b1;
            end
          end else begin
            x_q          <= sreg_q[DATA_W-1];
            sreg_q       <= sreg_q << 1;
            bit_cnt_q    <= bit_cnt_q + BitCntW'(1);
            frame_done_q <= data_penult;
          end
        end
        StGap: begin
          x_q <= 1'b0;
          if (gap_cnt_q == GapLast) begin
            state_q   <= StIdle;
            ready_q   <= 1'b1;
            gap_cnt_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
          end
        end
        default: begin
          state_q   <= StIdle;
          x_q       <= 1'b0;
          ready_q   <= 1'b1;
          bit_cnt_q <= '0;
          gap_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.busy        = ~ready_q;
  assign bus.x           = x_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;

endmodule
